// File: rtl/rr_dual_request_queue.sv
// rr_dual_request_queue
//   Requester-side companion to a two-request round-robin arbiter. Two clients
//   push transactions into private FIFOs. Each non-empty FIFO raises its
//   request line. A legal grant pops that FIFO's head onto one shared,
//   registered output channel, tagged with the client id.
//
// Ports
//   clk, rst_n        clock; asynchronous active-low reset
//   push_valid[1:0]   per-client push strobe
//   push_data_0/1     per-client transaction
//   push_ready[1:0]   per-client "FIFO not full" (registered count only)
//   requests[1:0]     per-client "FIFO non-empty" (registered count only)
//   grants[1:0]       arbiter response to requests, same cycle
//   out_valid         one-cycle pulse per legal grant, one cycle after it
//   out_id, out_data  granted client and its transaction (held when idle)
//   count_0/1         FIFO occupancy
//   protocol_error    sticky: arbiter granted both clients, or granted a
//                     client that was not requesting

// Per-client FIFO. Pointers wrap naturally because DEPTH is a power of two.
module rr_dual_request_queue_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);
    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [AW-1:0]               wr_ptr;
    logic [AW-1:0]               rd_ptr;
    logic                        do_push;
    logic                        do_pop;

    // Local guards keep the count from wrapping even if the caller misbehaves.
    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign head    = mem[rd_ptr];

    // Storage needs no reset; a reset empties the FIFO through the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end
endmodule

module rr_dual_request_queue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 push_valid,
    input  logic [WIDTH-1:0]           push_data_0,
    input  logic [WIDTH-1:0]           push_data_1,
    output logic [1:0]                 push_ready,
    output logic [1:0]                 requests,
    input  logic [1:0]                 grants,
    output logic                       out_valid,
    output logic                       out_id,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH):0]     count_0,
    output logic [$clog2(DEPTH):0]     count_1,
    output logic                       protocol_error
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic             id;
        logic [WIDTH-1:0] data;
    } out_t;

    logic [1:0][WIDTH-1:0] push_data;
    logic [1:0][WIDTH-1:0] head;
    logic [1:0][CW-1:0]    count;
    logic [1:0]            pop;
    logic                  grant_ok;
    logic                  err_now;
    out_t                  out_q;
    out_t                  out_d;

    assign push_data = {push_data_1, push_data_0};

    // ready/request come from the registered count only, so nothing the
    // arbiter drives back can loop combinationally into requests, and a
    // full FIFO refuses a push even in the cycle it is granted.
    for (genvar i = 0; i < 2; i++) begin : g_client
        rr_dual_request_queue_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .push      (push_valid[i] & push_ready[i]),
            .push_data (push_data[i]),
            .pop       (pop[i]),
            .head      (head[i]),
            .count     (count[i])
        );
        assign push_ready[i] = (count[i] != CW'(DEPTH));
        assign requests[i]   = (count[i] != '0);
    end

    assign count_0 = count[0];
    assign count_1 = count[1];

    // A legal grant is one-hot and lands on a requesting client. Anything
    // else nonzero is an arbiter violation: flagged, and nothing pops.
    assign grant_ok = ((grants == 2'b01) && requests[0]) ||
                      ((grants == 2'b10) && requests[1]);
    assign err_now  = (grants == 2'b11) || ((grants & ~requests) != 2'b00);
    assign pop      = grant_ok ? grants : 2'b00;

    // Output channel holds its last transaction while idle.
    always_comb begin
        out_d = out_q;
        if (grant_ok) begin
            out_d.id   = grants[1];
            out_d.data = head[grants[1]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid      <= 1'b0;
            out_q          <= '0;
            protocol_error <= 1'b0;
        end else begin
            out_valid      <= grant_ok;
            out_q          <= out_d;
            protocol_error <= protocol_error | err_now;
        end
    end

    assign out_id   = out_q.id;
    assign out_data = out_q.data;
endmodule
